// File: rtl/flash_word_fetch_pkg.sv
// Shared types and defaults for the flash word fetcher.
//   state_e      : FSM state encoding
//   DEF_*_CYC    : default latencies for a 54 MHz iclk
//   cnt_width()  : counter width wide enough for the largest latency
package flash_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_INIT,
    S_IDLE,
    S_READ
  } state_e;

  localparam int DEF_RESET_CYC = 28;
  localparam int DEF_INIT_CYC  = 3;
  localparam int DEF_READ_CYC  = 6;
  localparam int DEF_PAGE_CYC  = 2;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_RESET_CYC, DEF_INIT_CYC, DEF_READ_CYC);

endpackage

// File: rtl/flash_word_fetch_if.sv
// Request-side bus of the flash word fetcher.
//   ifl_req  : request toggle (master)
//   ifl_addr : byte address of the word's first byte (master)
//   ifl_inv  : single-cycle cache invalidate (master)
//   ofl_ack  : acknowledge toggle (slave)
//   ofl_dout : assembled word (slave)
//   obusy    : fetcher not idle (slave)
interface flash_word_fetch_if #(
  parameter int ADDR_W = 23,
  parameter int BYTES  = 2
);
  logic                ifl_req;
  logic [ADDR_W-1:0]   ifl_addr;
  logic                ifl_inv;
  logic                ofl_ack;
  logic [8*BYTES-1:0]  ofl_dout;
  logic                obusy;

  modport master (output ifl_req, ifl_addr, ifl_inv,
                  input  ofl_ack, ofl_dout, obusy);
  modport slave  (input  ifl_req, ifl_addr, ifl_inv,
                  output ofl_ack, ofl_dout, obusy);
endinterface

// File: rtl/flash_word_fetch_cache.sv
// One-entry last-word cache.
//   iclk, ireset_n : clock, synchronous active-low reset
//   lookup_i       : address being requested
//   inv_i          : clear valid
//   wr_i, tag_i, data_i : completion write (wins over inv_i)
//   hit_o, data_o  : hit flag and cached word
module flash_word_cache #(
  parameter int ADDR_W = 23,
  parameter int BYTES  = 2
) (
  input  logic               iclk,
  input  logic               ireset_n,
  input  logic [ADDR_W-1:0]  lookup_i,
  input  logic               inv_i,
  input  logic               wr_i,
  input  logic [ADDR_W-1:0]  tag_i,
  input  logic [8*BYTES-1:0] data_i,
  output logic               hit_o,
  output logic [8*BYTES-1:0] data_o
);
  logic               valid_q;
  logic [ADDR_W-1:0]  tag_q;
  logic [8*BYTES-1:0] data_q;

  // An invalidate in the same cycle as the lookup forces a miss.
  assign hit_o  = valid_q && !inv_i && (lookup_i == tag_q);
  assign data_o = data_q;

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      tag_q   <= tag_i;
      data_q  <= data_i;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/flash_word_fetch.sv
// Parallel NOR flash word fetcher: assembles BYTES flash bytes into one
// word per toggle request, with page-mode timing and a last-word cache.
//   iclk, ireset_n : clock, synchronous active-low reset
//   iFL_DQ         : flash data bus
//   oFL_*          : flash address and control pins
//   bus            : request-side handshake (slave modport)
//
// state   | meaning
// S_RESET | flash RST_N held low, ack tracks req
// S_INIT  | RST_N released, waiting before first access
// S_IDLE  | waiting for req != ack; cache hits answered here
// S_READ  | byte fetches in progress, completion on the last byte
module flash_word_fetch
  import flash_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int BYTES      = 2,
  parameter int LSB_FIRST  = 1,
  parameter int RESET_CYC  = DEF_RESET_CYC,
  parameter int INIT_CYC   = DEF_INIT_CYC,
  parameter int READ_CYC   = DEF_READ_CYC,
  parameter int PAGE_CYC   = DEF_PAGE_CYC,
  parameter int PAGE_BYTES = 16,
  parameter int CACHE_EN   = 1
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic [7:0]        iFL_DQ,
  output logic [ADDR_W-1:0] oFL_ADDR,
  output logic              oFL_RST_N,
  output logic              oFL_CE_N,
  output logic              oFL_OE_N,
  output logic              oFL_WE_N,
  output logic              oFL_WP_N,
  flash_word_fetch_if.slave bus
);
  localparam int CTR_W = cnt_width(RESET_CYC, INIT_CYC, READ_CYC);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PG_SH = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 0;

  state_e                   state_q;
  logic [CTR_W-1:0]         cnt_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     req_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [ADDR_W-1:0]        fl_addr_q;
  logic [BYTES-1:0][7:0]    word_q;
  logic [8*BYTES-1:0]       dout_q;
  logic                     ack_q;
  logic                     rst_n_q, ce_n_q, oe_n_q;

  logic [IDX_W-1:0]         lane;
  logic [BYTES-1:0][7:0]    word_nxt;
  logic [ADDR_W-1:0]        addr_nxt;
  logic                     last, expire, same_page, hit, cache_wr;
  logic [8*BYTES-1:0]       cache_data;

  assign lane      = (LSB_FIRST != 0) ? idx_q : IDX_W'(BYTES - 1) - idx_q;
  assign last      = (idx_q == IDX_W'(BYTES - 1));
  assign expire    = (cnt_q == CTR_W'(1));
  assign addr_nxt  = fl_addr_q + ADDR_W'(1);
  assign same_page = (PAGE_BYTES != 0) && ((fl_addr_q >> PG_SH) == (addr_nxt >> PG_SH));
  assign cache_wr  = (state_q == S_READ) && expire && last;

  always_comb begin
    word_nxt       = word_q;
    word_nxt[lane] = iFL_DQ;
  end

  if (CACHE_EN != 0) begin : g_cache
    flash_word_cache #(.ADDR_W(ADDR_W), .BYTES(BYTES)) u_cache (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .lookup_i (bus.ifl_addr),
      .inv_i    (bus.ifl_inv),
      .wr_i     (cache_wr),
      .tag_i    (addr_q),
      .data_i   (word_nxt),
      .hit_o    (hit),
      .data_o   (cache_data)
    );
  end else begin : g_nocache
    assign hit        = 1'b0;
    assign cache_data = '0;
  end

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      state_q   <= S_RESET;
      cnt_q     <= CTR_W'(RESET_CYC);
      idx_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      fl_addr_q <= '0;
      word_q    <= '0;
      dout_q    <= '0;
      ack_q     <= bus.ifl_req;
      rst_n_q   <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
    end else begin
      case (state_q)
        S_RESET: begin
          ack_q <= bus.ifl_req;
          if (expire) begin
            rst_n_q <= 1'b1;
            cnt_q   <= CTR_W'(INIT_CYC);
            state_q <= S_INIT;
          end else begin
            cnt_q <= cnt_q - CTR_W'(1);
          end
        end
        S_INIT: begin
          ack_q <= bus.ifl_req;
          if (expire) state_q <= S_IDLE;
          else        cnt_q   <= cnt_q - CTR_W'(1);
        end
        S_IDLE: begin
          if (bus.ifl_req != ack_q) begin
            req_q  <= bus.ifl_req;
            addr_q <= bus.ifl_addr;
            if (hit) begin
              ack_q  <= bus.ifl_req;
              dout_q <= cache_data;
            end else begin
              fl_addr_q <= bus.ifl_addr;
              ce_n_q    <= 1'b0;
              oe_n_q    <= 1'b0;
              idx_q     <= '0;
              cnt_q     <= CTR_W'(READ_CYC);
              state_q   <= S_READ;
            end
          end
        end
        S_READ: begin
          if (expire) begin
            word_q <= word_nxt;
            if (last) begin
              dout_q  <= word_nxt;
              ack_q   <= req_q;
              ce_n_q  <= 1'b1;
              oe_n_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              fl_addr_q <= addr_nxt;
              idx_q     <= idx_q + IDX_W'(1);
              cnt_q     <= same_page ? CTR_W'(PAGE_CYC) : CTR_W'(READ_CYC);
            end
          end else begin
            cnt_q <= cnt_q - CTR_W'(1);
          end
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

  assign oFL_ADDR     = fl_addr_q;
  assign oFL_RST_N    = rst_n_q;
  assign oFL_CE_N     = ce_n_q;
  assign oFL_OE_N     = oe_n_q;
  assign oFL_WE_N     = 1'b1;
  assign oFL_WP_N     = 1'b1;
  assign bus.ofl_ack  = ack_q;
  assign bus.ofl_dout = dout_q;
  assign bus.obusy    = (state_q != S_IDLE);
endmodule
